mem_read_buffer_avalon_interface: RTL and testbench
===================================================

Name: mem_read_buffer_avalon_interface

Overview:
Avalon-MM pipelined read master with an internal show-ahead FIFO. It is the read-side counterpart to the memory write port.
- Given a base byte address and a byte length, it streams 32-bit words from memory into the FIFO.
- Downstream logic pops words at its own pace.
- Credit-based flow control: accepted-but-unreturned reads plus FIFO occupancy never exceed FIFODEPTH.

Parameters:
DATAWIDTH, 32, width of data words
BYTEENABLEWIDTH, 4, bytes per word; this is also the address increment
ADDRESSWIDTH, 32, master address width
FIFODEPTH, 32, buffer entries
FIFODEPTH_LOG2, 5, log2(FIFODEPTH)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-low reset
control_read_base  in  32  start byte address, word aligned
control_read_length  in  32  transfer length in bytes; bits [1:0] are ignored
control_go  in  1  start pulse; sampled only in IDLE
control_done  out  1  high when idle and all requested data has been returned
user_read_buffer  in  1  pop the FIFO head
user_buffer_data  out  32  FIFO head, valid while user_data_available=1
user_data_available  out  1  FIFO non-empty
master_address  out  32  Avalon read address
master_read  out  1  Avalon read request
master_byteenable  out  4  constant 4'b1111
master_readdata  in  32  Avalon read data
master_readdatavalid  in  1  Avalon read response strobe
master_waitrequest  in  1  Avalon stall

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; master_read=0; master_address=0; control_done=1.
  - remaining=0, pending=0; FIFO flushed, so user_data_available=0.
  - The next cycle is fully clean: no request is issued.
- Internal state: address register, remaining (bytes), pending (0..FIFODEPTH), state enum {IDLE, READING, DRAIN}.
- IDLE:
  - control_go=1 with length>=4: latch base/length, go to READING, control_done=0 from the next cycle.
  - control_go=1 with length<4: stay in IDLE, control_done stays 1.
  - control_go outside IDLE is ignored.
- READING:
  - Credit = fifo_used + pending < FIFODEPTH.
  - master_read is registered and rises the cycle after go at the earliest.
  - master_read=1 when remaining>0 and credit is available.
  - Read accepted (master_read=1 and master_waitrequest=0): address += 4, remaining -= 4, pending += 1.
  - While master_waitrequest=1, master_read and master_address are held stable. Credit cannot shrink during a stall because the fifo_used+pending sum only falls.
  - When the last read is accepted (remaining reaches 0), go to DRAIN and drop master_read the following cycle.
- DRAIN: when pending==0, go to IDLE; control_done=1 the next cycle.
- Response path:
  - master_readdatavalid=1 writes master_readdata into the FIFO and decrements pending.
  - If pending==0, master_readdatavalid is ignored. This discards responses still in flight when reset was applied.
  - Simultaneous accept and readdatavalid: pending unchanged.
- FIFO:
  - Show-ahead: data written at cycle M is visible at M+1.
  - A pop while empty is ignored.
  - Simultaneous push and pop: count unchanged.
  - Credit makes overflow impossible; an overflow is an assertion failure in verification.
- Address wrap: the address wraps modulo 2^32 silently.
- control_done does not depend on the FIFO draining to the user; the user drains it independently.

Decomposition:
- Shared package mem_port_pkg:
  - DATAWIDTH/BYTEENABLEWIDTH constants
  - read-port state enum
  - BYTE_INC=4
- One sub-module: mem_read_fifo
  - Parameterised FIFODEPTH, show-ahead single-clock FIFO.
  - Ports: push, pop, data in/out, empty, used count.

Test Plan:
1. Reset → control_done=1, master_read=0, user_data_available=0, master_byteenable=4'hF. Hold reset low for 2 cycles mid-transfer → same values the cycle after release.
2. Basic transfer. Stimulus: base=0x1000, length=16, waitrequest=0, readdatavalid 2 cycles after each accept returning 0xA0..0xA3. Required: addresses 0x1000, 0x1004, 0x1008, 0x100C, one per cycle; pops return 0xA0..0xA3 in order; control_done rises 1 cycle after the 4th readdatavalid.
3. Stall. Stimulus: waitrequest=1 for 3 cycles on the 2nd request. Required: master_address stays 0x1004 with master_read=1 throughout; exactly 4 accepts in total, none skipped or duplicated.
4. Credit limit. Stimulus: FIFODEPTH=4, FIFODEPTH_LOG2=2, length=64, no pops, readdatavalid immediate. Required: 4 accepts, then master_read=0. One pop → exactly one further request issued.
5. Degenerate start. Stimulus: go with length=0, then with length=3. Required: master_read never asserts, control_done stays 1. A second go during READING of a 16-byte transfer is ignored: still exactly 4 reads.
6. Stale responses. Stimulus: reset asserted with pending=3, then 3 readdatavalid pulses after release. Required: user_data_available stays 0, control_done=1.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared constants and the read-port state encoding for the Avalon memory ports.
package mem_port_pkg;

    localparam int MEM_DATAWIDTH       = 32;
    localparam int MEM_BYTEENABLEWIDTH = 4;
    localparam int BYTE_INC            = 4;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_READING = 2'd1,
        RD_DRAIN   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/mem_read_fifo.sv
// Single-clock show-ahead FIFO: the head word is on dout whenever empty is low.
module mem_read_fifo #(
    parameter int DEPTH      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   used
);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   used_q, used_d;
    logic                  pop_eff;

    always_comb begin
        pop_eff  = pop & (used_q != '0);
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop_eff);
        used_d   = used_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop_eff);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
        end
    end

    // Storage needs no reset: only words behind a valid pointer are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (used_q == '0);
    assign used  = used_q;

    overflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop_eff && (used_q == (DEPTH_LOG2+1)'(DEPTH))));

endmodule

// File: rtl/mem_read_buffer_avalon_interface.sv
// Avalon-MM pipelined read master streaming a byte range into a show-ahead FIFO,
// with outstanding reads plus FIFO occupancy bounded by the FIFO depth.
module mem_read_buffer_avalon_interface
    import mem_port_pkg::*;
#(
    parameter int DATAWIDTH       = MEM_DATAWIDTH,
    parameter int BYTEENABLEWIDTH = MEM_BYTEENABLEWIDTH,
    parameter int ADDRESSWIDTH    = 32,
    parameter int FIFODEPTH       = 32,
    parameter int FIFODEPTH_LOG2  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDRESSWIDTH-1:0]    control_read_base,
    input  logic [31:0]                control_read_length,
    input  logic                       control_go,
    output logic                       control_done,
    input  logic                       user_read_buffer,
    output logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_data_available,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest,
    output rd_state_e                  dbg_state
);

    localparam int PW = FIFODEPTH_LOG2 + 1;
    localparam int CW = FIFODEPTH_LOG2 + 2;

    rd_state_e             state_q, state_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [31:0]           remaining_q, remaining_d;
    logic [PW-1:0]         pending_q, pending_d;
    logic                  read_q, read_d;
    logic                  done_q, done_d;

    logic                  accept, rsp_valid, pop_eff, credit_ok;
    logic                  fifo_empty;
    logic [PW-1:0]         fifo_used, fifo_used_d;
    logic [31:0]           len_words;

    always_comb begin
        accept      = read_q & ~master_waitrequest;
        // Responses with nothing outstanding are leftovers from before a reset.
        rsp_valid   = master_readdatavalid & (pending_q != '0);
        pop_eff     = user_read_buffer & ~fifo_empty;
        fifo_used_d = fifo_used + PW'(rsp_valid) - PW'(pop_eff);
        pending_d   = pending_q + PW'(accept) - PW'(rsp_valid);
        credit_ok   = ({1'b0, fifo_used_d} + {1'b0, pending_d}) < CW'(FIFODEPTH);
        len_words   = control_read_length & 32'hFFFF_FFFC;

        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        read_d      = read_q;

        case (state_q)
            RD_IDLE: begin
                read_d = 1'b0;
                if (control_go && (len_words != 32'd0)) begin
                    addr_d      = control_read_base;
                    remaining_d = len_words;
                    read_d      = credit_ok;
                    state_d     = RD_READING;
                end
            end
            RD_READING: begin
                if (accept) begin
                    addr_d      = addr_q + ADDRESSWIDTH'(BYTE_INC);
                    remaining_d = remaining_q - 32'(BYTE_INC);
                end
                // A stalled request stays on the bus unchanged until accepted.
                if (read_q && master_waitrequest) begin
                    read_d = 1'b1;
                end else if (remaining_d == 32'd0) begin
                    read_d  = 1'b0;
                    state_d = RD_DRAIN;
                end else begin
                    read_d = credit_ok;
                end
            end
            RD_DRAIN: begin
                read_d = 1'b0;
                if (pending_d == '0) begin
                    state_d = RD_IDLE;
                end
            end
            default: begin
                read_d  = 1'b0;
                state_d = RD_IDLE;
            end
        endcase

        done_d = (state_d == RD_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            pending_q   <= '0;
            read_q      <= 1'b0;
            done_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            read_q      <= read_d;
            done_q      <= done_d;
        end
    end

    mem_read_fifo #(
        .DEPTH      (FIFODEPTH),
        .DEPTH_LOG2 (FIFODEPTH_LOG2),
        .WIDTH      (DATAWIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_valid),
        .pop   (user_read_buffer),
        .din   (master_readdata),
        .dout  (user_buffer_data),
        .empty (fifo_empty),
        .used  (fifo_used)
    );

    assign user_data_available = ~fifo_empty;
    assign control_done        = done_q;
    assign master_address      = addr_q;
    assign master_read         = read_q;
    assign master_byteenable   = '1;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_mem_read_buffer_avalon_interface.sv
// Directed bench: a 32-deep instance against a scripted Avalon slave, plus a
// 4-deep instance for the credit limit.
module tb_mem_read_buffer_avalon_interface;
    import mem_port_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    // main instance
    logic [31:0] base = '0;
    logic [31:0] len = '0;
    logic        go = 1'b0;
    logic        done;
    logic        pop = 1'b0;
    logic [31:0] udata;
    logic        avail;
    logic [31:0] maddr;
    logic        mread;
    logic [3:0]  mbe;
    logic [31:0] mrdata = '0;
    logic        mrdv = 1'b0;
    logic        mwait = 1'b0;
    rd_state_e   dstate;

    // small instance
    logic [31:0] s_base = '0;
    logic [31:0] s_len = '0;
    logic        s_go = 1'b0;
    logic        s_done;
    logic        s_pop = 1'b0;
    logic [31:0] s_udata;
    logic        s_avail;
    logic [31:0] s_maddr;
    logic        s_mread;
    logic [3:0]  s_mbe;
    logic [31:0] s_mrdata = '0;
    logic        s_mrdv = 1'b0;
    logic        s_mwait = 1'b0;
    rd_state_e   s_dstate;

    // slave model state
    logic [31:0] acc_addr_q[$];
    int          acc_cyc_q[$];
    logic [31:0] exp_q[$];
    int          req_idx = 0;
    int          rsp_count = 0;
    int          stall_idx = -1;
    int          stall_left = 0;
    logic [31:0] stall_addr = '0;
    logic        pipe0 = 1'b0;
    logic        pipe1 = 1'b0;
    logic        read_seen = 1'b0;
    logic        manual_mode = 1'b0;
    int          manual_pulses = 0;
    int          last_rdv_cyc = 0;
    int          done_cyc = 0;
    logic        s_acc_prev = 1'b0;
    int          s_acc_cnt = 0;
    int          s_rsp_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_read_buffer_avalon_interface dut (
        .clk(clk), .reset(reset),
        .control_read_base(base), .control_read_length(len), .control_go(go),
        .control_done(done), .user_read_buffer(pop), .user_buffer_data(udata),
        .user_data_available(avail), .master_address(maddr), .master_read(mread),
        .master_byteenable(mbe), .master_readdata(mrdata),
        .master_readdatavalid(mrdv), .master_waitrequest(mwait), .dbg_state(dstate)
    );

    mem_read_buffer_avalon_interface #(.FIFODEPTH(4), .FIFODEPTH_LOG2(2)) dut_small (
        .clk(clk), .reset(reset),
        .control_read_base(s_base), .control_read_length(s_len), .control_go(s_go),
        .control_done(s_done), .user_read_buffer(s_pop), .user_buffer_data(s_udata),
        .user_data_available(s_avail), .master_address(s_maddr), .master_read(s_mread),
        .master_byteenable(s_mbe), .master_readdata(s_mrdata),
        .master_readdatavalid(s_mrdv), .master_waitrequest(s_mwait), .dbg_state(s_dstate)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Slave for the main instance. Everything is decided on the falling edge for
    // the rising edge that follows; responses come back 2 cycles after accept.
    always @(negedge clk) begin
        logic acc;
        if (!reset) begin
            pipe0 = 1'b0;
            pipe1 = 1'b0;
            mwait = 1'b0;
            mrdv  = 1'b0;
        end else begin
            if (stall_left > 0 && req_idx == stall_idx) begin
                mwait = 1'b1;
                stall_left--;
                check_eq("stall_read", 32'(mread), 32'd1);
                check_eq("stall_addr", maddr, stall_addr);
            end else begin
                mwait = 1'b0;
            end
            if (mread) read_seen = 1'b1;
            acc = mread && !mwait;
            if (acc) begin
                acc_addr_q.push_back(maddr);
                acc_cyc_q.push_back(cyc);
                req_idx++;
            end
            if (manual_mode) begin
                mrdv = (manual_pulses > 0);
                if (manual_pulses > 0) manual_pulses--;
            end else begin
                mrdv  = pipe1;
                pipe1 = pipe0;
                pipe0 = acc;
            end
            if (mrdv) begin
                mrdata = 32'hA0 + 32'(rsp_count);
                rsp_count++;
                last_rdv_cyc = cyc;
            end
        end
    end

    // Slave for the small instance: never stalls, answers 1 cycle after accept.
    always @(negedge clk) begin
        if (!reset) begin
            s_acc_prev = 1'b0;
            s_mrdv     = 1'b0;
        end else begin
            s_mrdv = s_acc_prev;
            if (s_mrdv) begin
                s_mrdata = 32'hB0 + 32'(s_rsp_cnt);
                s_rsp_cnt++;
            end
            s_acc_prev = s_mread;
            if (s_mread) s_acc_cnt++;
        end
    end

    task automatic clear_log();
        acc_addr_q.delete();
        acc_cyc_q.delete();
        exp_q.delete();
        req_idx    = 0;
        rsp_count  = 0;
        read_seen  = 1'b0;
        stall_left = 0;
        stall_idx  = -1;
    endtask

    task automatic start(input logic [31:0] b, input logic [31:0] l);
        @(negedge clk);
        base = b;
        len  = l;
        go   = 1'b1;
        @(negedge clk);
        go   = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (!done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        check_eq("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_accepts(input string tag, input logic [31:0] b, input int n);
        check_eq({tag, "_count"}, 32'(acc_addr_q.size()), 32'(n));
        for (int i = 0; i < acc_addr_q.size() && i < n; i++) begin
            check_eq({tag, "_addr"}, acc_addr_q[i], b + 32'(4 * i));
        end
    endtask

    task automatic pop_expect(input string tag, input int n);
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq({tag, "_avail"}, 32'(avail), 32'd1);
            check_eq({tag, "_data"}, udata, e);
            pop = 1'b1;
        end
        @(negedge clk);
        pop = 1'b0;
        check_eq({tag, "_empty"}, 32'(avail), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset state, then reset in the middle of a transfer
        repeat (3) @(negedge clk);
        check_eq("rst_done", 32'(done), 32'd1);
        check_eq("rst_read", 32'(mread), 32'd0);
        check_eq("rst_avail", 32'(avail), 32'd0);
        check_eq("rst_be", 32'(mbe), 32'hF);
        check_eq("rst_addr", maddr, 32'd0);
        check_eq("rst_state", 32'(dstate), 32'(RD_IDLE));
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_clean_read", 32'(mread), 32'd0);
        clear_log();
        start(32'h1000, 32'd16);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_done", 32'(done), 32'd1);
        check_eq("midrst_read", 32'(mread), 32'd0);
        check_eq("midrst_avail", 32'(avail), 32'd0);
        check_eq("midrst_be", 32'(mbe), 32'hF);
        repeat (4) @(negedge clk);

        // 2. basic 16-byte transfer
        clear_log();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
        start(32'h1000, 32'd16);
        check_eq("basic_busy", 32'(done), 32'd0);
        wait_done(100);
        check_eq("basic_done_lat", 32'(done_cyc - last_rdv_cyc), 32'd1);
        check_accepts("basic", 32'h1000, 4);
        for (int i = 1; i < acc_cyc_q.size(); i++) begin
            check_eq("basic_b2b", 32'(acc_cyc_q[i] - acc_cyc_q[0]), 32'(i));
        end
        pop_expect("basic_pop", 4);

        // 3. three-cycle stall on the second request
        clear_log();
        stall_idx  = 1;
        stall_left = 3;
        stall_addr = 32'h1004;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
        start(32'h1000, 32'd16);
        wait_done(100);
        check_eq("stall_used_up", 32'(stall_left), 32'd0);
        check_accepts("stall", 32'h1000, 4);
        pop_expect("stall_pop", 4);

        // 5. degenerate lengths, then a go ignored while reading
        clear_log();
        start(32'h3000, 32'd0);
        repeat (4) @(negedge clk);
        check_eq("len0_done", 32'(done), 32'd1);
        check_eq("len0_read", 32'(read_seen), 32'd0);
        start(32'h3000, 32'd3);
        repeat (4) @(negedge clk);
        check_eq("len3_done", 32'(done), 32'd1);
        check_eq("len3_read", 32'(read_seen), 32'd0);
        clear_log();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
        start(32'h3000, 32'd16);
        base = 32'h5000;
        len  = 32'd16;
        go   = 1'b1;
        @(negedge clk);
        go   = 1'b0;
        wait_done(100);
        check_accepts("rego", 32'h3000, 4);
        repeat (4) @(negedge clk);
        check_eq("rego_after", 32'(acc_addr_q.size()), 32'd4);
        pop_expect("rego_pop", 4);

        // 6. reset with three reads outstanding, then stale responses
        clear_log();
        manual_mode = 1'b1;
        start(32'h1000, 32'd12);
        repeat (6) @(negedge clk);
        check_eq("stale_accepts", 32'(acc_addr_q.size()), 32'd3);
        check_eq("stale_busy", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        manual_pulses = 3;
        repeat (6) @(negedge clk);
        check_eq("stale_pulses", 32'(rsp_count), 32'd3);
        check_eq("stale_avail", 32'(avail), 32'd0);
        check_eq("stale_done", 32'(done), 32'd1);
        check_eq("stale_read", 32'(mread), 32'd0);
        manual_mode = 1'b0;

        // 4. credit limit on the 4-deep instance, no pops
        @(negedge clk);
        s_base = 32'h0;
        s_len  = 32'd64;
        s_go   = 1'b1;
        @(negedge clk);
        s_go   = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("credit_accepts", 32'(s_acc_cnt), 32'd4);
        check_eq("credit_read", 32'(s_mread), 32'd0);
        check_eq("credit_avail", 32'(s_avail), 32'd1);
        check_eq("credit_head", s_udata, 32'hB0);
        check_eq("credit_busy", 32'(s_done), 32'd0);
        s_pop = 1'b1;
        @(negedge clk);
        s_pop = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("credit_one_more", 32'(s_acc_cnt), 32'd5);
        check_eq("credit_read2", 32'(s_mread), 32'd0);
        check_eq("credit_head2", s_udata, 32'hB1);
        check_eq("credit_addr", s_maddr, 32'h14);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
